hazard_lights_ctrl: RTL and testbench

Flight-line hazard-light controller for the control-station board top level. A free-running clock divider produces a slow step enable, and a 4-state Moore FSM advances a 3-lamp pattern once per step. The wind-direction switches select the pattern: calm, right-to-left, or left-to-right. Everything runs in a single clock domain; the divider output is a clock enable, never a derived clock.

---
 rtl/hazard_lights_ctrl.sv | 87 ++++++++
 tb/tb_hazard_lights_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/hazard_lights_ctrl.sv
// Flight-line hazard-light controller: a free-running divider produces a step
// enable, and a four-state Moore FSM walks a three-lamp pattern selected by SW.
module hazard_lights_ctrl #(
    parameter int unsigned DIV_BIT = 25,
    parameter bit          USE_DIV = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] SW,
    output logic [2:0] LEDR
);

    typedef enum logic [2:0] {
        S101 = 3'b101,
        S010 = 3'b010,
        S100 = 3'b100,
        S001 = 3'b001
    } state_e;

    state_e state_q;
    state_e state_d;
    logic   tick;

    // Only the low DIV_BIT+1 bits of the divider ever reach the tick, and they
    // count and wrap exactly as the low bits of a wider counter would.
    generate
        if (USE_DIV) begin : gen_div
            logic [DIV_BIT:0] div_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    div_q <= '0;
                end else begin
                    div_q <= div_q + {{DIV_BIT{1'b0}}, 1'b1};
                end
            end

            assign tick = &div_q;
        end else begin : gen_nodiv
            assign tick = 1'b1;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        if (tick) begin
            unique case (SW)
                2'b01: begin
                    case (state_q)
                        S001:    state_d = S010;
                        S010:    state_d = S100;
                        S100:    state_d = S001;
                        S101:    state_d = S010;
                        default: state_d = S101;
                    endcase
                end
                2'b10: begin
                    case (state_q)
                        S100:    state_d = S010;
                        S010:    state_d = S001;
                        S001:    state_d = S100;
                        S101:    state_d = S010;
                        default: state_d = S101;
                    endcase
                end
                default: begin
                    // Calm (00, and 11 treated the same): alternate 101 and 010.
                    case (state_q)
                        S101:    state_d = S010;
                        default: state_d = S101;
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S101;
        end else begin
            state_q <= state_d;
        end
    end

    assign LEDR = state_q;

endmodule

// File: tb/tb_hazard_lights_ctrl.sv
// Bench for hazard_lights_ctrl: one instance stepping every clock, one with a
// short divider, both checked against a lamp-position reference model.
module tb_hazard_lights_ctrl;

   logic       clk;
   logic       resetA;
   logic [1:0] swA;
   logic [2:0] ledA;
   logic       resetB;
   logic [1:0] swB;
   logic [2:0] ledB;

   int vecCount  = 0;
   int missCount = 0;

   hazard_lights_ctrl #(.DIV_BIT(2), .USE_DIV(1'b0)) dutA (
      .clk  (clk),
      .reset(resetA),
      .SW   (swA),
      .LEDR (ledA)
   );

   hazard_lights_ctrl #(.DIV_BIT(2), .USE_DIV(1'b1)) dutB (
      .clk  (clk),
      .reset(resetB),
      .SW   (swB),
      .LEDR (ledB)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Guard against a runaway simulation.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model: a directional pattern is one lit lamp at a position
   // 0..2 (0 = rightmost) that moves one place per step; calm alternates.
   function automatic logic [2:0] modelNext(input logic [2:0] pat, input logic [1:0] sw);
      int pos;
      if (sw == 2'b01 || sw == 2'b10) begin
         if (pat == 3'b001)      pos = 0;
         else if (pat == 3'b010) pos = 1;
         else if (pat == 3'b100) pos = 2;
         else return 3'b010;
         if (sw == 2'b01) pos = (pos + 1) % 3;
         else             pos = (pos + 2) % 3;
         return 3'(1 << pos);
      end
      return (pat == 3'b101) ? 3'b010 : 3'b101;
   endfunction

   task automatic checkOutput(input string tag, input logic [2:0] observed, input logic [2:0] expected);
      vecCount++;
      assert (observed === expected)
      else begin
         missCount++;
         $error("[TB] FAIL %s: got %b expected %b", tag, observed, expected);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic runTableA(input string tag, input logic [1:0] sw, input logic [2:0] seq[$]);
      swA = sw;
      foreach (seq[i]) begin
         applyStimulus();
         checkOutput($sformatf("%s[%0d]", tag, i), ledA, seq[i]);
      end
   endtask

   initial begin
      logic [2:0] modelA;
      logic [2:0] modelB;
      logic [2:0] seq[$];

      resetA = 1'b0;
      resetB = 1'b0;
      swA    = 2'b00;
      swB    = 2'b00;

      // Reset takes effect before any clock edge.
      #1;
      resetA = 1'b1;
      resetB = 1'b1;
      #1;
      checkOutput("resetA_async", ledA, 3'b101);
      checkOutput("resetB_async", ledB, 3'b101);
      applyStimulus();
      applyStimulus();
      checkOutput("resetA_held", ledA, 3'b101);
      resetA = 1'b0;

      seq = '{3'b010, 3'b101, 3'b010, 3'b101, 3'b010, 3'b101};
      runTableA("calm", 2'b00, seq);

      seq = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
      runTableA("r2l", 2'b01, seq);

      seq = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001};
      runTableA("l2r", 2'b10, seq);

      seq = '{3'b101, 3'b010, 3'b101, 3'b010};
      runTableA("calm2", 2'b00, seq);

      seq = '{3'b100};
      runTableA("toS100", 2'b01, seq);

      seq = '{3'b101, 3'b010, 3'b101};
      runTableA("sw11", 2'b11, seq);

      // Asynchronous reset between edges while the pattern shows 100.
      seq = '{3'b010, 3'b100};
      runTableA("preReset", 2'b01, seq);
      resetA = 1'b1;
      #1;
      checkOutput("midResetA", ledA, 3'b101);
      #1;
      resetA = 1'b0;
      applyStimulus();
      checkOutput("postReset0", ledA, 3'b010);
      applyStimulus();
      checkOutput("postReset1", ledA, 3'b100);

      // Randomized direction changes against the model.
      modelA = 3'b100;
      for (int i = 0; i < 200; i++) begin
         swA = 2'($urandom_range(0, 3));
         modelA = modelNext(modelA, swA);
         applyStimulus();
         checkOutput($sformatf("rand[%0d]", i), ledA, modelA);
      end
      checkOutput("resetB_held", ledB, 3'b101);

      // Divider instance: a step lands on every 8th edge after release, and
      // SW changed after edge 10 is only seen at edge 16.
      resetB = 1'b0;
      modelB = 3'b101;
      for (int e = 1; e <= 24; e++) begin
         if (e % 8 == 0) modelB = modelNext(modelB, swB);
         applyStimulus();
         checkOutput($sformatf("div[%0d]", e), ledB, modelB);
         if (e == 10) swB = 2'b01;
      end
      checkOutput("div_edge24", ledB, 3'b001);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
